// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU operand path: the fetch FSM state
// encoding, the debug view of the operand-fetch unit and default widths.
package cpu_pkg;

    localparam int OPF_DATA_W = 16;
    localparam int OPF_ADDR_W = 3;

    localparam logic [2:0] OPF_IDLE_ENC = 3'd0;

    typedef enum logic [2:0] {
        IDLE    = OPF_IDLE_ENC,
        ISSUE_A = 3'd1,
        ISSUE_B = 3'd2,
        CAPT_B  = 3'd3,
        OUT     = 3'd4
    } opf_state_t;

    // Debug view: FSM state plus the forward decisions taken for this request.
    typedef struct packed {
        opf_state_t state;
        logic       fwdA;
        logic       fwdB;
        logic       useB;
    } opf_dbg_t;

    function automatic logic opfBusy(input opf_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/opf_fwd_capture.sv
// One operand's forward path: remembers whether the write-back in the issue
// cycle hit the source register, and picks forwarded data over RF data.
module opf_fwd_capture
    import cpu_pkg::*;
#(
    parameter int DATA_W = OPF_DATA_W,
    parameter int ADDR_W = OPF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic              wbEn,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic [DATA_W-1:0] rfRdata,
    output logic              fwdHit,
    output logic [DATA_W-1:0] operand
);

    logic              hitNow;
    logic [DATA_W-1:0] fwdData;

    assign hitNow = wbEn && (wbAddr == srcAddr);

    // The RF returns the old value on read-during-write, so only a write in the
    // issue cycle itself needs to be captured here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwdHit  <= 1'b0;
            fwdData <= '0;
        end else if (sample) begin
            fwdHit <= hitNow;
            if (hitNow) begin
                fwdData <= wbData;
            end
        end
    end

    assign operand = fwdHit ? fwdData : rfRdata;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads source A then optionally source B through the single
// synchronous RF read port and hands the pair to the ALU under valid/ready.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_W = OPF_DATA_W,
    parameter int ADDR_W = OPF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_src_a,
    input  logic [ADDR_W-1:0] req_src_b,
    input  logic              req_use_b,
    input  logic              flush,
    output logic              rf_ren,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output opf_dbg_t          dbg
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
    // an operand pair transfers on a rising edge with op_valid && op_ready, and
    // op_a/op_b stay constant for as long as op_valid is high.

    opf_state_t        state;
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic              useB;
    logic              fwdA;
    logic              fwdB;
    logic [DATA_W-1:0] capA;
    logic [DATA_W-1:0] capB;
    logic              sampleA;
    logic              sampleB;

    assign sampleA = (state == ISSUE_A);
    assign sampleB = (state == ISSUE_B) && useB;

    opf_fwd_capture #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) uCapA (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sampleA),
        .srcAddr(srcA),
        .wbEn   (wb_en),
        .wbAddr (wb_addr),
        .wbData (wb_data),
        .rfRdata(rf_rdata),
        .fwdHit (fwdA),
        .operand(capA)
    );

    opf_fwd_capture #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) uCapB (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sampleB),
        .srcAddr(srcB),
        .wbEn   (wb_en),
        .wbAddr (wb_addr),
        .wbData (wb_data),
        .rfRdata(rf_rdata),
        .fwdHit (fwdB),
        .operand(capB)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rf_ren    <= 1'b0;
            rf_raddr  <= '0;
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            srcA      <= '0;
            srcB      <= '0;
            useB      <= 1'b0;
        end else if (flush && opfBusy(state)) begin
            // Abort wins over op_ready; captured operands are left as they were.
            state     <= IDLE;
            req_ready <= 1'b1;
            rf_ren    <= 1'b0;
            op_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        srcA      <= req_src_a;
                        srcB      <= req_src_b;
                        useB      <= req_use_b;
                        req_ready <= 1'b0;
                        rf_ren    <= 1'b1;
                        rf_raddr  <= req_src_a;
                        state     <= ISSUE_A;
                    end
                end
                ISSUE_A: begin
                    rf_ren <= useB;
                    if (useB) begin
                        rf_raddr <= srcB;
                    end
                    state <= ISSUE_B;
                end
                ISSUE_B: begin
                    op_a   <= capA;
                    rf_ren <= 1'b0;
                    if (useB) begin
                        state <= CAPT_B;
                    end else begin
                        op_b     <= '0;
                        op_valid <= 1'b1;
                        state    <= OUT;
                    end
                end
                CAPT_B: begin
                    op_b     <= capB;
                    op_valid <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rf_ren    <= 1'b0;
                    op_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg = '{state: state, fwdA: fwdA, fwdB: fwdB, useB: useB};

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural RF, snapshot-semantics operand model,
// expected queue popped by a monitor on every ALU handshake.
module tb_operand_fetch;
    import cpu_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int EXP_W = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_use_b, flush;
    logic [AW-1:0] req_src_a, req_src_b;
    logic          rf_ren;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          op_valid, op_ready;
    logic [DW-1:0] op_a, op_b;
    opf_dbg_t      dbg;

    operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_a(req_src_a), .req_src_b(req_src_b), .req_use_b(req_use_b),
        .flush(flush),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .dbg(dbg)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous read, old data on read-during-write.
    logic [DW-1:0] rf [8];
    always @(posedge clk) begin
        if (rf_ren) rf_rdata <= rf[rf_raddr];
        if (wb_en) rf[wb_addr] <= wb_data;
    end

    // Architectural view of the register file, as the bench believes it to be.
    logic [DW-1:0] model [8];

    logic [EXP_W-1:0] exp_q[$];
    int nChecks = 0;
    int nPass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (wb_en) model[wb_addr] = wb_data;
        #1;
    endtask

    task automatic drive_wb(input int k, input int wbCyc, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit rnd);
        if (k == wbCyc) begin
            wb_en = 1'b1; wb_addr = wa; wb_data = wd;
        end else if (rnd) begin
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = AW'($urandom_range(0, 7));
            wb_data = DW'($urandom_range(0, 65535));
        end else begin
            wb_en = 1'b0;
        end
    endtask

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // flushAt: 0 none, 1..3 flush in that cycle after acceptance, 4 flush in the accept cycle.
    task automatic run_req(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic ub,
                           input int wbCyc, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input bit rnd, input int hold, input bit holdWr, input int flushAt);
        logic [DW-1:0] snapA, snapB;
        int acc, n;
        bit abort;
        snapA = '0; snapB = '0; abort = 0;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_src_a = a; req_src_b = b; req_use_b = ub;
        flush = (flushAt == 4);
        drive_wb(0, wbCyc, wa, wd, rnd);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        acc = cyc;
        for (int k = 1; k <= 3 && !abort; k++) begin
            if (k == 3 && !ub) break;
            drive_wb(k, wbCyc, wa, wd, rnd);
            flush = (flushAt == k);
            if (k == 1) begin
                check("rf_ren_a", rf_ren, 1);
                check("rf_raddr_a", rf_raddr, a);
            end else if (k == 2) begin
                check("rf_ren_b", rf_ren, ub);
                if (ub) check("rf_raddr_b", rf_raddr, b);
            end else begin
                check("rf_ren_capt", rf_ren, 0);
            end
            tick();
            if (k == 1) snapA = model[a];
            if (k == 2) snapB = ub ? model[b] : '0;
            if (flush) begin
                flush = 1'b0;
                check("flush_state", 32'(dbg.state), 32'(IDLE));
                check("flush_req_ready", req_ready, 1);
                check("flush_op_valid", op_valid, 0);
                abort = 1;
            end else if (k == 2 && (flushAt == 0 || flushAt == 4)) begin
                exp_q.push_back({32'(acc + (ub ? 3 : 2)), snapA, snapB});
            end
        end
        if (abort) begin
            wb_en = 1'b0;
            repeat (2) begin
                tick();
                check("post_flush_idle", op_valid, 0);
            end
            return;
        end
        n = 0;
        while (!op_valid && n < 8) begin
            drive_wb(10, -1, '0, '0, rnd);
            tick();
            n++;
        end
        check("op_valid_timeout", op_valid, 1);
        for (int h = 0; h < hold; h++) begin
            op_ready = 1'b0;
            if (holdWr) drive_wb(10, 10, 3'd2, 16'hFFFF, 0);
            else drive_wb(10, -1, '0, '0, rnd);
            tick();
            check("op_valid_hold", op_valid, 1);
        end
        op_ready = 1'b1;
        drive_wb(10, -1, '0, '0, rnd);
        tick();
        op_ready = 1'b0;
        wb_en = 1'b0;
        check("op_valid_drop", op_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    task automatic reset_mid_issue_b();
        wb_en = 1'b0;
        req_valid = 1'b1; req_src_a = 3'd1; req_src_b = 3'd3; req_use_b = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_reset_state", 32'(dbg.state), 32'(ISSUE_B));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_ready", req_ready, 1);
        check("async_rst_rf_ren", rf_ren, 0);
        check("async_rst_rf_raddr", rf_raddr, 0);
        check("async_rst_op_valid", op_valid, 0);
        check("async_rst_op_a", op_a, 0);
        check("async_rst_op_b", op_b, 0);
        check("async_rst_state", 32'(dbg.state), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit prevValid = 0;
    int riseCyc = 0;
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst_n) begin
            prevValid = 0;
        end else begin
            if (op_valid && exp_q.size() == 0) begin
                if (!prevValid) check("unexpected_op_valid", op_valid, 0);
            end else if (op_valid) begin
                e = exp_q[0];
                if (!prevValid) riseCyc = cyc;
                check("op_a", op_a, e[31:16]);
                check("op_b", op_b, e[15:0]);
                if (op_ready) begin
                    check("latency", riseCyc, e[63:32]);
                    void'(exp_q.pop_front());
                end
            end
            prevValid = op_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_src_a = '0; req_src_b = '0; req_use_b = 1'b0;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rf_ren", rf_ren, 0);
        check("rst_rf_raddr", rf_raddr, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_state", 32'(dbg.state), 32'(IDLE));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) rf_write(AW'(i), DW'($urandom_range(0, 65535)));
        rf_write(3'd2, 16'h1234);
        rf_write(3'd5, 16'h00FF);
        rf_write(3'd7, 16'hBEEF);

        run_req(3'd2, 3'd5, 1'b1, -1, '0, '0, 0, 0, 0, 0);
        run_req(3'd7, 3'd0, 1'b0, -1, '0, '0, 0, 0, 0, 0);
        run_req(3'd2, 3'd5, 1'b1, 2, 3'd5, 16'hA5A5, 0, 0, 0, 0);
        rf_write(3'd5, 16'h00FF);
        run_req(3'd2, 3'd5, 1'b1, 3, 3'd5, 16'hA5A5, 0, 0, 0, 0);
        run_req(3'd4, 3'd4, 1'b1, 1, 3'd4, 16'h5A5A, 0, 0, 0, 0);
        run_req(3'd2, 3'd5, 1'b1, -1, '0, '0, 0, 4, 1, 0);
        rf_write(3'd2, 16'h1234);
        run_req(3'd2, 3'd5, 1'b1, -1, '0, '0, 0, 0, 0, 3);
        run_req(3'd2, 3'd5, 1'b1, -1, '0, '0, 0, 0, 0, 0);
        run_req(3'd7, 3'd1, 1'b1, -1, '0, '0, 0, 0, 0, 4);
        reset_mid_issue_b();
        run_req(3'd2, 3'd7, 1'b1, -1, '0, '0, 0, 1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a, b;
            logic ub;
            int fa;
            a  = AW'($urandom_range(0, 7));
            b  = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, 7));
            ub = 1'($urandom_range(0, 1));
            fa = 0;
            case ($urandom_range(0, 9))
                0: fa = 1;
                1: fa = 2;
                2: fa = ub ? 3 : 0;
                3: fa = 4;
                default: fa = 0;
            endcase
            run_req(a, b, ub, -1, '0, '0, 1, $urandom_range(0, 3), 0, fa);
        end

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side counterpart to the CPU's loadable data registers.
- Accepts an operand request from decode and reads source A, then optionally source B, through the register file's single synchronous read port.
- Applies write-back forwarding for a same-cycle write.
- Presents the operand pair to the ALU under a valid/ready handshake and holds it stable until consumed.

Parameters:
- DATA_W, 16, operand/register data width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decode presents a request
- req_ready  out  1  unit can accept a request
- req_src_a  in  ADDR_W  source A register address
- req_src_b  in  ADDR_W  source B register address
- req_use_b  in  1  1 = two-operand instruction; 0 = read A only
- flush  in  1  synchronous abort of any in-flight request
- rf_ren  out  1  register file read enable
- rf_raddr  out  ADDR_W  register file read address
- rf_rdata  in  DATA_W  read data, valid the cycle after rf_ren
- wb_en  in  1  write-back strobe to register file
- wb_addr  in  ADDR_W  write-back address
- wb_data  in  DATA_W  write-back data
- op_valid  out  1  operand pair valid
- op_ready  in  1  ALU accepts operands
- op_a  out  DATA_W  operand A
- op_b  out  DATA_W  operand B (0 when req_use_b=0)

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, req_ready=1, rf_ren=0, rf_raddr=0, op_valid=0, op_a=0, op_b=0.
  - All latched addresses, use_b flag and forward flags cleared.
  - Reset mid-operation abandons the request silently.
- States: IDLE, ISSUE_A, ISSUE_B, CAPT_B, OUT.
- IDLE:
  - req_ready=1 here only.
  - On req_valid: latch src_a, src_b, use_b; go to ISSUE_A.
- ISSUE_A:
  - rf_ren=1, rf_raddr=src_a.
  - Record fwd_a = wb_en && wb_addr==src_a, and latch wb_data if set.
  - Go to ISSUE_B.
- ISSUE_B:
  - Capture op_a = fwd_a ? latched wb_data : rf_rdata.
  - If use_b: rf_ren=1, rf_raddr=src_b; record fwd_b likewise; go to CAPT_B.
  - Else: rf_ren=0, op_b=0, go to OUT.
- CAPT_B: capture op_b = fwd_b ? latched wb_data : rf_rdata; go to OUT.
- OUT:
  - op_valid=1; op_a/op_b held stable.
  - On op_ready: op_valid=0 next cycle, go to IDLE.
- Latency, acceptance edge to op_valid high:
  - 3 cycles with use_b=1.
  - 2 cycles with use_b=0.
- Register file contract:
  - Read-during-write to the same address returns the old value.
  - The forward therefore covers only a write in the issue cycle itself.
  - Writes after the issue cycle are ignored: snapshot semantics. Decode owns RAW stalls beyond that.
- src_a == src_b: both reads are still issued; each forward is evaluated independently.
- rf_ren is low in IDLE, CAPT_B and OUT; rf_raddr holds its last value when rf_ren=0.
- flush:
  - In any non-IDLE state: next state IDLE, op_valid=0 next cycle.
  - op_a/op_b keep their last values.
  - flush has priority over op_ready.
  - flush in IDLE has no effect; a req_valid in that same cycle is still accepted.
- No back-to-back acceptance: at least one IDLE cycle between requests.

Decomposition:
- Shared package cpu_pkg:
  - state enum (opf_state_t)
  - DATA_W/ADDR_W defaults
  - IDLE encoding constant
- One natural sub-module: opf_fwd_capture. It holds the forward-compare flag, the latched wb_data and the capture mux; it is instantiated once for A and once for B.

Test Plan:
- RF[2]=0x1234, RF[5]=0x00FF; request src_a=2, src_b=5, use_b=1 -> rf_raddr 2 then 5; op_valid 3 cycles after accept; op_a=0x1234, op_b=0x00FF.
- use_b=0, src_a=7, RF[7]=0xBEEF -> only one rf_ren pulse; op_valid after 2 cycles; op_a=0xBEEF, op_b=0x0000.
- wb_en=1, wb_addr=5, wb_data=0xA5A5 in the ISSUE_B cycle (old RF[5]=0x00FF) -> op_b=0xA5A5. The same write one cycle later -> op_b=0x00FF.
- Hold op_ready=0 for 4 cycles in OUT while wb writes RF[2]=0xFFFF -> op_valid stays 1; op_a remains 0x1234 throughout; released on op_ready=1.
- Assert flush in CAPT_B -> IDLE next cycle, op_valid never rises, req_ready=1. A new request completes normally.
- Drop rst_n asynchronously mid-ISSUE_B -> all outputs 0 and req_ready=1 immediately. After release, a fresh request yields correct operands.
